// File: rtl/jtag_shift_sequencer.sv
// jtag_shift_sequencer
// JTAG master that owns the TAP pins and runs one complete IR or DR scan per command,
// starting and ending in Run-Test/Idle. TCK is derived from clk: each tick is DIV clk
// cycles low followed by DIV clk cycles high. After reset it pulses TRST and walks the
// TAP through Test-Logic-Reset into Run-Test/Idle before accepting commands.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_is_ir selects IR vs DR scan,
//                       cmd_len is the bit count (0 = 64), cmd_data is TDI, LSB first
//   rsp_valid/ready     response handshake; rsp_data holds captured TDO, bit i = i-th shift
//   jtag_TCK/TMS/TDI    TAP drive pins
//   jtag_TDO            TAP data return
//   jtag_TRST           TAP reset, active-high
module jtag_shift_sequencer #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_ir,
  input  logic [5:0]  cmd_len,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        jtag_TCK,
  output logic        jtag_TMS,
  output logic        jtag_TDI,
  input  logic        jtag_TDO,
  output logic        jtag_TRST
);

  localparam int unsigned PW = $clog2(DIV) + 1;
  localparam logic [PW-1:0] PhaseLast = PW'(DIV - 1);

  typedef enum logic [2:0] {
    StRstSeq,
    StIdle,
    StHead,
    StShift,
    StTail,
    StResp
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          trst_q, trst_d;
  logic [6:0]    tick_q, tick_d;   // tick index within the current state
  logic [6:0]    len_q, len_d;     // effective scan length, 1..64
  logic          is_ir_q, is_ir_d;
  logic [63:0]   shift_q, shift_d;
  logic [63:0]   cap_q, cap_d;

  logic       in_tick;
  logic       phase_last;
  logic       tick_end;
  logic [6:0] head_last;

  // TRST still high means this is the first cycle out of reset: no tick is running yet.
  assign in_tick = (state_q == StHead) || (state_q == StShift) || (state_q == StTail) ||
                   ((state_q == StRstSeq) && !trst_q);
  assign phase_last = (phase_q == PhaseLast);
  assign tick_end   = in_tick && tck_q && phase_last;
  assign head_last  = is_ir_q ? 7'd3 : 7'd2;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    trst_d  = trst_q;
    tick_d  = tick_q;
    len_d   = len_q;
    is_ir_d = is_ir_q;
    shift_d = shift_q;
    cap_d   = cap_q;

    if (in_tick) begin
      if (phase_last) begin
        phase_d = '0;
        tck_d   = ~tck_q;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end

    // TDO is taken in the first cycle TCK is high.
    if ((state_q == StShift) && tck_q && (phase_q == '0)) begin
      cap_d[tick_q[5:0]] = jtag_TDO;
    end

    // TMS/TDI for the next tick are loaded at tick_end so they change with TCK falling.
    case (state_q)
      StRstSeq: begin
        if (trst_q) begin
          trst_d  = 1'b0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          tck_d   = 1'b0;
          phase_d = '0;
          tick_d  = '0;
        end else if (tick_end) begin
          if (tick_q == 7'd5) begin
            state_d = StIdle;
            tms_d   = 1'b0;
          end else begin
            tick_d = tick_q + 7'd1;
            tms_d  = (tick_q != 7'd4);  // ticks 0..4 hold TMS=1, tick 5 drops it
          end
        end
      end

      StIdle: begin
        if (cmd_valid) begin
          state_d = StHead;
          is_ir_d = cmd_is_ir;
          len_d   = (cmd_len == 6'd0) ? 7'd64 : {1'b0, cmd_len};
          shift_d = cmd_data;
          cap_d   = '0;
          tick_d  = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          tck_d   = 1'b0;
          phase_d = '0;
        end
      end

      StHead: begin
        if (tick_end) begin
          if (tick_q == head_last) begin
            state_d = StShift;
            tick_d  = '0;
            tdi_d   = shift_q[0];
            shift_d = shift_q >> 1;
            tms_d   = (len_q == 7'd1);
          end else begin
            tick_d = tick_q + 7'd1;
            // IR: 1,1,0,0 ; DR: 1,0,0
            tms_d  = is_ir_q ? (tick_q == 7'd0) : 1'b0;
          end
        end
      end

      StShift: begin
        if (tick_end) begin
          if (tick_q == len_q - 7'd1) begin
            state_d = StTail;
            tick_d  = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            tick_d  = tick_q + 7'd1;
            tdi_d   = shift_q[0];
            shift_d = shift_q >> 1;
            tms_d   = (tick_q + 7'd2 == len_q);
          end
        end
      end

      StTail: begin
        if (tick_end) begin
          if (tick_q == 7'd0) begin
            tick_d = 7'd1;
            tms_d  = 1'b0;
          end else begin
            state_d = StResp;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
          end
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StRstSeq;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRstSeq;
      phase_q <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trst_q  <= 1'b1;
      tick_q  <= '0;
      len_q   <= '0;
      is_ir_q <= 1'b0;
      shift_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      trst_q  <= trst_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      is_ir_q <= is_ir_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = cap_q;
  assign jtag_TCK  = tck_q;
  assign jtag_TMS  = tms_q;
  assign jtag_TDI  = tdi_q;
  assign jtag_TRST = trst_q;

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// Bench for jtag_shift_sequencer: a tick-list model predicts every pin each cycle,
// plus literal expectations for the reset sequence and a few directed scans.
module tb_jtag_shift_sequencer;

  localparam int unsigned DIV = 2;

  localparam int MRst  = 0;
  localparam int MTick = 1;
  localparam int MIdle = 2;
  localparam int MResp = 3;

  typedef struct packed {
    logic tck;
    logic tms;
    logic tdi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_ir;
  logic [5:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        jtag_TCK;
  logic        jtag_TMS;
  logic        jtag_TDI;
  logic        jtag_TDO;
  logic        jtag_TRST;

  // 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low
  int tdo_mode = 0;
  assign jtag_TDO = (tdo_mode == 0) ? jtag_TDI : (tdo_mode == 1) ? ~jtag_TDI : (tdo_mode == 2);

  always #5 clk = ~clk;

  jtag_shift_sequencer #(.DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_is_ir (cmd_is_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .jtag_TCK  (jtag_TCK),
    .jtag_TMS  (jtag_TMS),
    .jtag_TDI  (jtag_TDI),
    .jtag_TDO  (jtag_TDO),
    .jtag_TRST (jtag_TRST)
  );

  // Model and compare state (owned by the compare process)
  exp_t        q[$];
  int          mode = MRst;
  int          after_mode = MIdle;
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          acc_cyc = 0;
  int          ticks = 0;
  bit          watch_rst = 1'b0;
  bit          resp_seen = 1'b0;
  bit          prev_tck = 1'b0;
  logic [63:0] tms_rec = '0;
  logic [63:0] tdi_rec = '0;
  logic [63:0] exp_rsp = '0;

  // Literal expectations for directed scans (owned by the stimulus process)
  bit          lit_en = 1'b0;
  bit          lit_seq = 1'b0;
  logic [63:0] lit_rsp = '0;
  logic [63:0] lit_tms = '0;
  logic [63:0] lit_tdi = '0;
  int          lit_ticks = 0;
  int          lit_lat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic push_tick(input logic tms, input logic tdi);
    exp_t e;
    for (int i = 0; i < int'(2 * DIV); i++) begin
      e.tck = (i >= int'(DIV));
      e.tms = tms;
      e.tdi = tdi;
      q.push_back(e);
    end
  endtask

  function automatic logic tdo_of(input logic d);
    case (tdo_mode)
      0:       return d;
      1:       return ~d;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare process: checks this cycle against the model, then advances the model
  // using the inputs that the next rising edge will sample.
  initial begin
    exp_t        cur;
    logic [63:0] m;
    int          len;
    forever begin
      @(negedge clk);
      cyc++;
      if (watch_rst) rel_cyc++;
      if (jtag_TCK && !prev_tck) begin
        ticks++;
        tms_rec = {tms_rec[62:0], jtag_TMS};
        tdi_rec = {tdi_rec[62:0], jtag_TDI};
      end
      prev_tck = jtag_TCK;

      if (mode == MRst) begin
        cur.tck = 1'b0; cur.tms = 1'b1; cur.tdi = 1'b0;
      end else if (mode == MTick) begin
        cur = q[0];
      end else begin
        cur.tck = 1'b0; cur.tms = 1'b0; cur.tdi = 1'b0;
      end
      check("tck", 64'(jtag_TCK), 64'(cur.tck));
      check("tms", 64'(jtag_TMS), 64'(cur.tms));
      check("tdi", 64'(jtag_TDI), 64'(cur.tdi));
      check("trst", 64'(jtag_TRST), 64'(mode == MRst));
      check("cmd_ready", 64'(cmd_ready), 64'(mode == MIdle));
      check("rsp_valid", 64'(rsp_valid), 64'(mode == MResp));
      if (mode == MRst) check("rsp_data_reset", rsp_data, 64'd0);
      if (mode == MResp) check("rsp_data", rsp_data, exp_rsp);

      if (watch_rst && rel_cyc == 1) check("trst_release", 64'(jtag_TRST), 64'd0);
      if (watch_rst && cmd_ready) begin
        check("rst_ready_cycle", 64'(rel_cyc), 64'd25);
        check("rst_ticks", 64'(ticks), 64'd6);
        check("rst_tms_seq", tms_rec & 64'h3f, 64'b111110);
        watch_rst = 1'b0;
      end
      if (mode == MResp && !resp_seen) begin
        resp_seen = 1'b1;
        if (lit_en) begin
          check("lit_rsp_data", rsp_data, lit_rsp);
          check("lit_ticks", 64'(ticks), 64'(lit_ticks));
          check("lit_latency", 64'(cyc - acc_cyc), 64'(lit_lat));
          if (lit_seq) begin
            m = (64'd1 << lit_ticks) - 64'd1;
            check("lit_tms_seq", tms_rec & m, lit_tms);
            check("lit_tdi_seq", tdi_rec & m, lit_tdi);
          end
        end
      end

      if (reset) begin
        mode = MRst;
        watch_rst = 1'b0;
        q.delete();
      end else begin
        case (mode)
          MRst: begin
            for (int j = 0; j < 6; j++) push_tick(logic'(j < 5), 1'b0);
            mode = MTick;
            after_mode = MIdle;
            watch_rst = 1'b1;
            rel_cyc = 0;
            ticks = 0;
            tms_rec = '0;
            tdi_rec = '0;
          end
          MTick: begin
            void'(q.pop_front());
            if (q.size() == 0) mode = after_mode;
          end
          MIdle: begin
            if (cmd_valid) begin
              len = (cmd_len == 6'd0) ? 64 : int'(cmd_len);
              if (cmd_is_ir) begin
                push_tick(1'b1, 1'b0); push_tick(1'b1, 1'b0);
                push_tick(1'b0, 1'b0); push_tick(1'b0, 1'b0);
              end else begin
                push_tick(1'b1, 1'b0); push_tick(1'b0, 1'b0); push_tick(1'b0, 1'b0);
              end
              exp_rsp = '0;
              for (int k = 0; k < len; k++) begin
                push_tick(logic'(k == len - 1), cmd_data[k]);
                exp_rsp[k] = tdo_of(cmd_data[k]);
              end
              push_tick(1'b1, 1'b0);
              push_tick(1'b0, 1'b0);
              mode = MTick;
              after_mode = MResp;
              acc_cyc = cyc;
              ticks = 0;
              tms_rec = '0;
              tdi_rec = '0;
              resp_seen = 1'b0;
            end
          end
          default: begin
            if (rsp_ready) mode = MIdle;
          end
        endcase
      end
    end
  end

  // Stimulus: inputs change 1 time unit after the rising edge.
  task automatic issue(input logic ir, input logic [5:0] len, input logic [63:0] data);
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_is_ir = ir;
    cmd_len   = len;
    cmd_data  = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 300) begin
        $display("FAIL cmd_ready_timeout: got no ready after %0d cycles, expected ready", n);
        $fatal(1, "stimulus stopped");
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_is_ir = 1'($urandom_range(0, 1));
    cmd_len   = 6'($urandom_range(0, 63));
    cmd_data  = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(input int stall);
    int n;
    n = 0;
    while (!rsp_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 400) begin
        $display("FAIL rsp_valid_timeout: got no response after %0d cycles, expected one", n);
        $fatal(1, "stimulus stopped");
      end
      if (!rsp_valid) cmd_valid = 1'($urandom_range(0, 1));
    end
    repeat (stall) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'($urandom_range(0, 1));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_is_ir = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // DR, 8 bits of 0xA5, loopback: 13 ticks, response 53 cycles after accept
    tdo_mode  = 0;
    lit_en    = 1'b1;
    lit_seq   = 1'b1;
    lit_rsp   = 64'hA5;
    lit_ticks = 13;
    lit_lat   = 53;
    lit_tms   = 64'b1000000000110;
    lit_tdi   = 64'b0001010010100;
    issue(1'b0, 6'd8, 64'hA5);
    wait_rsp(0);

    // IR, 5 bits of 0x01, TDO tied high
    tdo_mode  = 2;
    lit_rsp   = 64'h1F;
    lit_ticks = 11;
    lit_lat   = 45;
    lit_tms   = 64'b11000000110;
    lit_tdi   = 64'b00001000000;
    issue(1'b1, 6'd5, 64'h01);
    wait_rsp(1);

    // length 0 means 64
    tdo_mode  = 0;
    lit_seq   = 1'b0;
    lit_rsp   = 64'hDEADBEEF_CAFEF00D;
    lit_ticks = 69;
    lit_lat   = 277;
    issue(1'b0, 6'd0, 64'hDEADBEEF_CAFEF00D);
    wait_rsp(2);

    // response backpressure for 10 cycles
    lit_en   = 1'b0;
    tdo_mode = 1;
    issue(1'b0, 6'd12, {$urandom, $urandom});
    wait_rsp(10);

    // one-cycle reset landing around shift bit 3 of a DR scan
    tdo_mode = 0;
    issue(1'b0, 6'd16, {$urandom, $urandom});
    repeat (25) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int          r;
      logic [5:0]  len;
      r = $urandom_range(0, 9);
      case (r)
        0:       len = 6'd0;
        1:       len = 6'd1;
        2:       len = 6'd63;
        default: len = 6'($urandom_range(0, 63));
      endcase
      tdo_mode = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(1'($urandom_range(0, 1)), len, {$urandom, $urandom});
      wait_rsp(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6));
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
